// File: rtl/tff_using_srff_counter.sv
// ---------------------------------------------------------------------------
// tff_using_srff_counter
//
// This is a modulo-MOD synchronous up/down counter. Every state bit is a
// T flip-flop, and each T flip-flop is built from an SR flip-flop core
// using the T->SR excitation S = T & ~Q, R = T & Q. Every state change goes
// through that excitation path, including load and wrap. The count register
// is never written directly.
//
// Modules in this file:
//   sr_cell                 one SR flip-flop bit with async active-high reset
//   tff_sr                  one T flip-flop built from an sr_cell
//   tff_using_srff_counter  top-level counter
//
// Parameters (top):
//   W    counter width in bits
//   the count modulus is parameter MOD, legal range 2..2^W; the count runs 0..MOD-1
//
// Ports (top):
//   clk         clock; all state updates happen on the rising edge
//   rst         asynchronous, active-high reset
//   en          count enable
//   up          direction: 1 = up, 0 = down
//   load        synchronous load request; takes priority over en
//   load_val    value to load (W bits)
//   q           current count, taken straight from the SR cores
//   tc          terminal count (combinational); high in the cycle whose edge wraps
//   load_err    one-cycle registered pulse after a rejected load
//   sr_illegal  sticky flag: some SR cell saw S=R=1 since the last reset
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sr_cell: a single SR flip-flop bit.
//   clk  clock
//   rst  async active-high reset, clears q
//   s    set request
//   r    reset request
//   q    stored bit
// S=R=1 is treated as hold. The parent module flags it.
// ---------------------------------------------------------------------------
module sr_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    // NOTE: sequential state is assigned with <= only, so every flop in the
    // design samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            unique case ({s, r})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                default: q <= q;      // 00 hold; 11 illegal, also hold
            endcase
        end
    end

endmodule

// ---------------------------------------------------------------------------
// tff_sr: a T flip-flop built from an SR core.
//   clk  clock
//   rst  async active-high reset
//   t    toggle request
//   q    stored bit
//   s    set excitation fed to the core (exported for self-checking)
//   r    reset excitation fed to the core (exported for self-checking)
// ---------------------------------------------------------------------------
module tff_sr (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic s,
    output logic r
);

    // The excitation is derived from the current Q, so S and R can never
    // both be high at the same time.
    assign s = t & ~q;
    assign r = t &  q;

    sr_cell u_core (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .r   (r),
        .q   (q)
    );

endmodule

// ---------------------------------------------------------------------------
// tff_using_srff_counter: top-level counter.
// ---------------------------------------------------------------------------
module tff_using_srff_counter #(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         load_err,
    output logic         sr_illegal
);

    // Largest legal count. MOD is held in W+1 bits so that MOD = 2^W does
    // not overflow when load_val is range-checked.
    localparam logic [W-1:0] MAX_CNT = W'(MOD - 1);
    localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

    // Each action selects one T vector. Listed in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_REJECT,
        ACT_WRAP_UP,
        ACT_INC,
        ACT_WRAP_DN,
        ACT_DEC
    } act_t;

    act_t         act;
    logic         load_ok;
    logic         at_max;
    logic         at_zero;
    logic [W-1:0] inc_t;
    logic [W-1:0] dec_t;
    logic [W-1:0] t_vec;
    logic [W-1:0] s_vec;
    logic [W-1:0] r_vec;

    assign load_ok = ({1'b0, load_val} < MOD_EXT);
    assign at_max  = (q == MAX_CNT);
    assign at_zero = (q == '0);

    // Binary increment toggles bit i when all lower bits are 1. Binary
    // decrement toggles bit i when all lower bits are 0.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave one unassigned and infer a latch.
    always_comb begin
        logic all_ones;
        logic all_zeros;
        inc_t     = '0;
        dec_t     = '0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < W; i++) begin
            inc_t[i]  = all_ones;
            dec_t[i]  = all_zeros;
            all_ones  = all_ones  &  q[i];
            all_zeros = all_zeros & ~q[i];
        end
    end

    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = load_ok ? ACT_LOAD : ACT_REJECT;
        end else if (en) begin
            if (up) begin
                act = at_max  ? ACT_WRAP_UP : ACT_INC;
            end else begin
                act = at_zero ? ACT_WRAP_DN : ACT_DEC;
            end
        end
    end

    // The T vector is the XOR distance from the current count to the
    // target count. A toggle mask is the only way to steer the flops.
    always_comb begin
        t_vec = '0;
        unique case (act)
            ACT_LOAD:    t_vec = q ^ load_val;
            ACT_WRAP_UP: t_vec = q;               // toggle every set bit -> 0
            ACT_INC:     t_vec = inc_t;
            ACT_WRAP_DN: t_vec = q ^ MAX_CNT;     // q is 0 here -> MAX_CNT
            ACT_DEC:     t_vec = dec_t;
            default:     t_vec = '0;              // hold or rejected load
        endcase
    end

    for (genvar g = 0; g < W; g++) begin : g_bit
        tff_sr u_tff (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[g]),
            .q   (q[g]),
            .s   (s_vec[g]),
            .r   (r_vec[g])
        );
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err   <= 1'b0;
            sr_illegal <= 1'b0;
        end else begin
            load_err   <= (act == ACT_REJECT);
            sr_illegal <= sr_illegal | (|(s_vec & r_vec));
        end
    end

endmodule

// File: tb/tb_tff_using_srff_counter.sv
// ---------------------------------------------------------------------------
// Testbench for tff_using_srff_counter.
//
// Two instances share one clock and one reset: dut_a (W=4, MOD=10) and
// dut_b (W=4, MOD=16). At each step the bench drives one instance and
// pushes the expected next state into a scoreboard queue. After the edge it
// pops the entry and compares it with the DUT outputs. Expected values come
// from an arithmetic model of the counter.
// ---------------------------------------------------------------------------
module tb_tff_using_srff_counter;

    logic       clk = 1'b0;
    logic       rst;

    logic       en_a, up_a, load_a;
    logic [3:0] lv_a, q_a;
    logic       tc_a, err_a, ill_a;

    logic       en_b, up_b, load_b;
    logic [3:0] lv_b, q_b;
    logic       tc_b, err_b, ill_b;

    always #5 clk = ~clk;

    tff_using_srff_counter #(.W(4), .MOD(10)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en_a),
        .up         (up_a),
        .load       (load_a),
        .load_val   (lv_a),
        .q          (q_a),
        .tc         (tc_a),
        .load_err   (err_a),
        .sr_illegal (ill_a)
    );

    tff_using_srff_counter #(.W(4), .MOD(16)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en_b),
        .up         (up_b),
        .load       (load_b),
        .load_val   (lv_b),
        .q          (q_b),
        .tc         (tc_b),
        .load_err   (err_b),
        .sr_illegal (ill_b)
    );

    typedef struct {
        int         sel;
        logic [3:0] q;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mq[2];
    int         mods[2] = '{10, 16};
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic e, input logic u,
                         input logic l, input logic [3:0] v);
        en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; lv_a = '0;
        en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; lv_b = '0;
        if (sel == 0) begin
            en_a = e; up_a = u; load_a = l; lv_a = v;
        end else begin
            en_b = e; up_b = u; load_b = l; lv_b = v;
        end
    endtask

    // One clock of stimulus for instance sel, checked against the model.
    task automatic step(input int sel, input logic e, input logic u,
                        input logic l, input logic [3:0] v);
        exp_t       x;
        int         m;
        int         cur;
        int         nxt;
        logic       nerr;
        logic       etc;
        logic [3:0] sr_a;
        logic [3:0] sr_b;
        m   = mods[sel];
        cur = int'(mq[sel]);
        @(negedge clk);
        drive(sel, e, u, l, v);
        #1;
        etc = e & ~l & ((u & (cur == m - 1)) | (~u & (cur == 0)));
        check("tc", 32'(sel == 0 ? tc_a : tc_b), 32'(etc));
        sr_a = dut_a.s_vec & dut_a.r_vec;
        sr_b = dut_b.s_vec & dut_b.r_vec;
        check("s_and_r_a", 32'(sr_a), 32'd0);
        check("s_and_r_b", 32'(sr_b), 32'd0);

        nxt  = cur;
        nerr = 1'b0;
        if (l) begin
            if (int'(v) < m) nxt = int'(v);
            else             nerr = 1'b1;
        end else if (e) begin
            if (u) nxt = (cur == m - 1) ? 0 : cur + 1;
            else   nxt = (cur == 0) ? m - 1 : cur - 1;
        end
        x.sel = sel;
        x.q   = 4'(nxt);
        x.err = nerr;
        sb.push_back(x);
        mq[sel] = 4'(nxt);

        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("q",        32'(x.sel == 0 ? q_a   : q_b),   32'(x.q));
        check("load_err", 32'(x.sel == 0 ? err_a : err_b), 32'(x.err));
        check("sr_illegal_a", 32'(ill_a), 32'd0);
        check("sr_illegal_b", 32'(ill_b), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 4'd0);
        mq[0] = '0;
        mq[1] = '0;
        @(posedge clk);
        #1;
        check("rst_q_a",   32'(q_a),   32'd0);
        check("rst_q_b",   32'(q_b),   32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_ill_a", 32'(ill_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Count up through the wrap: 1..9, 0, 1, 2.
        for (int i = 0; i < 12; i++) step(0, 1'b1, 1'b1, 1'b0, 4'd0);
        // Count down through the wrap: 1, 0, 9, 8.
        for (int i = 0; i < 4; i++)  step(0, 1'b1, 1'b0, 1'b0, 4'd0);
        // A legal load wins over en; an out-of-range load is rejected.
        step(0, 1'b1, 1'b1, 1'b1, 4'd7);
        step(0, 1'b1, 1'b1, 1'b1, 4'd12);
        // Hold with up toggling; load_err must drop after one cycle.
        for (int i = 0; i < 5; i++)  step(0, 1'b0, 1'(i), 1'b0, 4'd0);
        // Move to 5, then reset asynchronously in the middle of a cycle.
        step(0, 1'b0, 1'b0, 1'b1, 4'd4);
        step(0, 1'b1, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q_a",   32'(q_a),   32'd0);
        check("async_rst_q_b",   32'(q_b),   32'd0);
        check("async_rst_err_a", 32'(err_a), 32'd0);
        mq[0] = '0;
        mq[1] = '0;
        #1 rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++)  step(0, 1'b1, 1'b1, 1'b0, 4'd0);
        // Random mix on the MOD=10 instance, including rejected loads.
        for (int i = 0; i < 40; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));

        // Power-of-two modulus (16 = 2^W): the wraps coincide with natural overflow and underflow.
        step(1, 1'b0, 1'b0, 1'b1, 4'd15);
        step(1, 1'b1, 1'b1, 1'b0, 4'd0);   // 15 -> 0
        step(1, 1'b1, 1'b0, 1'b0, 4'd0);   // 0 -> 15
        step(1, 1'b1, 1'b0, 1'b0, 4'd0);   // 15 -> 14
        step(1, 1'b1, 1'b1, 1'b0, 4'd0);   // 14 -> 15
        step(1, 1'b1, 1'b1, 1'b0, 4'd0);   // 15 -> 0
        for (int i = 0; i < 40; i++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tff_using_srff_counter.md
Name: tff_using_srff_counter

Overview:
- Modulo-MOD synchronous up/down counter built entirely from T flip-flops. Each T flip-flop is emulated with an SR flip-flop core using the T->SR excitation S = T&~Q, R = T&Q.
- This is the reverse conversion direction to the SR-from-T conversion block, scaled to a counter with real sequential behaviour.
- It sits in the flip-flop conversion set as the reference counter used by conversion benches.
- All state changes, including load and wrap, go through the T->SR excitation path. No direct D-style writes to state.

Parameters:
- W, 4, counter width in bits.
- MOD, 10, count modulus, legal range 2..2^W; count range is 0..MOD-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load request; has priority over en.
- load_val  input  W  value to load.
- q  output  W  current count; SR core outputs.
- tc  output  1  terminal count, combinational.
- load_err  output  1  registered one-cycle pulse when load is rejected.
- sr_illegal  output  1  sticky flag: some SR cell ever saw S=R=1.

Behaviour:
- Reset (async, rst=1): q=0, load_err=0, sr_illegal=0, effective immediately, independent of clk. Reset mid-count discards state. First count after rst deasserts starts from 0.
- SR cell (per bit) on posedge:
  - S=1, R=0 -> Q=1.
  - S=0, R=1 -> Q=0.
  - S=0, R=0 -> hold.
  - S=1, R=1 -> hold Q and set sr_illegal=1. sr_illegal stays set until rst.
- Per-bit excitation: S[i] = T[i] & ~q[i]; R[i] = T[i] & q[i]. By construction S&R never occurs; sr_illegal is a self-check and must stay 0 in normal operation.
- T vector selection, by priority:
  1. load=1 and load_val < MOD: T = q ^ load_val. q becomes load_val next cycle.
  2. load=1 and load_val >= MOD: T = 0, q holds, load_err=1 next cycle.
  3. en=1, up=1, q == MOD-1: T = q, so q wraps to 0.
  4. en=1, up=1, otherwise: T[0]=1, T[i] = &q[i-1:0]. Binary increment.
  5. en=1, up=0, q == 0: T = q ^ (MOD-1), so q wraps to MOD-1.
  6. en=1, up=0, otherwise: T[0]=1, T[i] = &~q[i-1:0]. Binary decrement.
  7. en=0: T = 0, hold.
- Latency: one cycle from the sampled inputs to the new q.
- load_err: registered pulse, high exactly one cycle after a rejected load, otherwise 0.
- tc = en & ~load & ((up & q == MOD-1) | (~up & q == 0)). It is high during the cycle in which the wrap will occur.
- MOD = 2^W: the wrap cases coincide with natural binary overflow/underflow; results are identical.
- up may change every cycle. The direction is sampled at each edge together with en.
- q is never outside 0..MOD-1 after reset. An out-of-range state cannot arise because all loads are checked.

Test Plan:
- rst=1 for 1 cycle, then en=1, up=1 for 12 cycles (W=4, MOD=10) -> q = 1..9, 0, 1, 2. tc=1 only while q=9. sr_illegal=0.
- en=1, up=0 from q=2 for 4 cycles -> q = 1, 0, 9, 8. tc=1 only while q=0.
- load=1, load_val=7, en=1 -> q=7 next cycle (load wins). Then load=1, load_val=12 -> q stays 7, load_err=1 for exactly one cycle.
- en=0 with up toggling for 5 cycles from q=7 -> q holds 7. tc=0. load_err=0.
- Assert rst asynchronously mid-cycle while counting at q=5 -> q=0 before the next posedge. After release, counting resumes 1, 2, ...
- W=4, MOD=16 instance: up from 15 -> 0, down from 0 -> 15. Bench checks S&R==0 on every cycle; sr_illegal=0 throughout.
